pc_stack_unit: RTL and testbench

//   Parametrised program counter with return-address stack; successor to the fixed 16-bit PC.
//   - Provides reset, increment by a step, absolute load, signed relative branch,
//     and call/return through an internal LIFO with full/empty and sticky error flags.
//   - Sits in the fetch stage: feeds the instruction-memory address; DOut drives the shared data bus on read.

---
 rtl/pc_stack_unit.sv | 114 +++++++++++
 tb/tb_pc_stack_unit.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/pc_stack_unit.sv
// pc_stack_unit: program counter with a return-address stack.
// One PC operation per enabled cycle, with priority call > ret > l > br > inc.
// The stack keeps count in sp (0..DEPTH). The ovf and unf flags are sticky
// and are cleared only by reset. DOut is a gated combinational read of pc.
module pc_stack_unit #(
  parameter int AW         = 16,
  parameter int DEPTH      = 8,
  parameter int STEP       = 1,
  parameter int RESET_ADDR = 0,
  localparam int IW        = $clog2(DEPTH),
  localparam int SPW       = IW + 1
) (
  input  logic          clk,
  input  logic          re,
  input  logic          cs,
  input  logic          inc,
  input  logic          l,
  input  logic [AW-1:0] load,
  input  logic          br,
  input  logic [AW-1:0] offset,
  input  logic          call,
  input  logic          ret,
  input  logic          r,
  output logic [AW-1:0] pc,
  output logic [AW-1:0] DOut,
  output logic [SPW-1:0] sp,
  output logic          full,
  output logic          empty,
  output logic          ovf,
  output logic          unf
);

  localparam logic [AW-1:0]  STEP_W  = AW'(STEP);
  localparam logic [AW-1:0]  RST_PC  = AW'(RESET_ADDR);
  localparam logic [SPW-1:0] SP_FULL = SPW'(DEPTH);

  logic [AW-1:0]  r_pc;
  logic [SPW-1:0] r_sp;
  logic           r_ovf;
  logic           r_unf;
  logic [AW-1:0]  r_stack [DEPTH];

  logic           w_full;
  logic           w_empty;
  logic [AW-1:0]  w_pc_step;
  logic [AW-1:0]  w_pc_br;
  logic [IW-1:0]  w_push_idx;
  logic [IW-1:0]  w_top_idx;
  logic           w_push;

  // The stack decodes and the modulo-2^AW PC arithmetic.
  // When the stack is full, the low bits of sp wrap to 0. Subtracting 1 then
  // still yields DEPTH-1 as the top index, so no extra bit is needed.
  always_comb begin
    w_full     = (r_sp == SP_FULL);
    w_empty    = (r_sp == '0);
    w_pc_step  = r_pc + STEP_W;
    w_pc_br    = r_pc + offset;
    w_push_idx = r_sp[IW-1:0];
    w_top_idx  = r_sp[IW-1:0] - 1'b1;
    w_push     = cs & call & ~w_full;
  end

  // Update the PC, sp and sticky flags. The priority chain drops any
  // lower-priority request that arrives in the same cycle.
  always_ff @(posedge clk or negedge re) begin
    if (!re) begin
      r_pc  <= RST_PC;
      r_sp  <= '0;
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else if (cs) begin
      if (call) begin
        if (!w_full) begin
          r_sp <= r_sp + 1'b1;
          r_pc <= load;
        end else begin
          r_ovf <= 1'b1;
        end
      end else if (ret) begin
        if (!w_empty) begin
          r_sp <= r_sp - 1'b1;
          r_pc <= r_stack[w_top_idx];
        end else begin
          r_unf <= 1'b1;
        end
      end else if (l) begin
        r_pc <= load;
      end else if (br) begin
        r_pc <= w_pc_br;
      end else if (inc) begin
        r_pc <= w_pc_step;
      end
    end
  end

  // Write the return address into stack storage. The contents are
  // don't-care after reset, so the storage itself has no reset.
  always_ff @(posedge clk) begin
    if (re && w_push) r_stack[w_push_idx] <= w_pc_step;
  end

  // Drive the outputs. DOut reads zero unless the unit is selected and read.
  always_comb begin
    pc    = r_pc;
    sp    = r_sp;
    full  = w_full;
    empty = w_empty;
    ovf   = r_ovf;
    unf   = r_unf;
    DOut  = (cs && r) ? r_pc : '0;
  end

endmodule

// File: tb/tb_pc_stack_unit.sv
// Directed bench for pc_stack_unit (AW=16, DEPTH=8, STEP=1, RESET_ADDR=0).
module tb_pc_stack_unit;

  logic        clk = 1'b0;
  logic        re, cs, inc, l, br, call, ret, r;
  logic [15:0] load, offset;
  logic [15:0] pc, DOut;
  logic [3:0]  sp;
  logic        full, empty, ovf, unf;

  int n_chk = 0;
  int n_err = 0;
  logic [15:0] exp_ret [$];
  logic [15:0] tgt;

  pc_stack_unit #(.AW(16), .DEPTH(8), .STEP(1), .RESET_ADDR(0)) dut (
    .clk(clk), .re(re), .cs(cs), .inc(inc), .l(l), .load(load), .br(br),
    .offset(offset), .call(call), .ret(ret), .r(r), .pc(pc), .DOut(DOut),
    .sp(sp), .full(full), .empty(empty), .ovf(ovf), .unf(unf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    inc = 0; l = 0; br = 0; call = 0; ret = 0;
  endtask

  // One active edge, then settle before the bench samples.
  task automatic tick();
    @(posedge clk); #1;
    idle();
  endtask

  initial begin
    re = 0; cs = 1; r = 0; load = 0; offset = 0; idle();
    #12;
    chk("rst_pc", 32'(pc), 0);
    chk("rst_sp", 32'(sp), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    @(negedge clk); re = 1;

    // Test 1: reach pc=5 with sp=2, then assert an asynchronous reset mid-cycle.
    @(negedge clk);
    call = 1; load = 16'h0003; tick();
    call = 1; load = 16'h0004; tick();
    inc = 1; tick();
    chk("t1_pc5", 32'(pc), 32'h5);
    chk("t1_sp2", 32'(sp), 2);
    #2 re = 0; #1;
    chk("t1_async_pc", 32'(pc), 0);
    chk("t1_async_sp", 32'(sp), 0);
    chk("t1_async_empty", 32'(empty), 1);
    chk("t1_async_ovf", 32'(ovf), 0);
    chk("t1_async_unf", 32'(unf), 0);
    @(negedge clk); re = 1;

    // Test 2: increment, load, then increment again. Check the DOut gating.
    inc = 1; tick(); chk("t2_inc1", 32'(pc), 1);
    inc = 1; tick(); chk("t2_inc2", 32'(pc), 2);
    inc = 1; tick(); chk("t2_inc3", 32'(pc), 3);
    r = 1; #1 chk("t2_dout_rd", 32'(DOut), 3);
    r = 0; #1 chk("t2_dout_nord", 32'(DOut), 0);
    l = 1; load = 16'd1000; tick(); chk("t2_load", 32'(pc), 1000);
    inc = 1; tick(); chk("t2_inc4", 32'(pc), 1001);
    inc = 1; tick(); chk("t2_inc5", 32'(pc), 1002);
    r = 1; #1 chk("t2_dout_1002", 32'(DOut), 1002);
    r = 0;

    // Test 3: a negative branch, then wrap-around on both adders.
    l = 1; load = 16'h0010; tick();
    br = 1; offset = 16'hFFF8; tick(); chk("t3_br_neg", 32'(pc), 32'h0008);
    l = 1; load = 16'hFFFF; tick();
    inc = 1; tick(); chk("t3_inc_wrap", 32'(pc), 32'h0000);
    l = 1; load = 16'h0002; tick();
    br = 1; offset = 16'hFFFD; tick(); chk("t3_br_wrap", 32'(pc), 32'hFFFF);

    // Test 4: one call followed by its return.
    l = 1; load = 16'h0020; tick();
    call = 1; load = 16'h0100; tick();
    chk("t4_call_pc", 32'(pc), 32'h0100);
    chk("t4_call_sp", 32'(sp), 1);
    ret = 1; tick();
    chk("t4_ret_pc", 32'(pc), 32'h0021);
    chk("t4_ret_sp", 32'(sp), 0);
    chk("t4_ret_empty", 32'(empty), 1);

    // Test 5: fill the stack, overflow it, drain it, then underflow it.
    // Nine calls are issued but only eight push, so eight return addresses are expected.
    exp_ret.push_back(16'h0022);
    for (int i = 0; i < 9; i++) begin
      tgt = 16'h1000 + 16'(i * 16'h10);
      call = 1; load = tgt; tick();
      if (i < 7) exp_ret.push_back(tgt + 16'h1);
      if (i == 7) begin
        chk("t5_full8", 32'(full), 1);
        chk("t5_no_ovf_yet", 32'(ovf), 0);
      end
    end
    chk("t5_sp8", 32'(sp), 8);
    chk("t5_ovf", 32'(ovf), 1);
    chk("t5_pc_8th", 32'(pc), 32'h1070);
    for (int i = 0; i < 8; i++) begin
      ret = 1; tick();
      chk($sformatf("t5_ret%0d", i), 32'(pc), 32'(exp_ret.pop_back()));
    end
    chk("t5_sp0", 32'(sp), 0);
    chk("t5_unf_pre", 32'(unf), 0);
    ret = 1; tick();
    chk("t5_unf", 32'(unf), 1);
    chk("t5_pc_hold", 32'(pc), 32'h0022);
    chk("t5_sp_hold", 32'(sp), 0);
    chk("t5_ovf_sticky", 32'(ovf), 1);

    // Test 6: with cs=0 all state holds and DOut reads zero.
    cs = 0; r = 1; inc = 1; call = 1; load = 16'h0555; tick();
    chk("t6_cs0_pc", 32'(pc), 32'h0022);
    chk("t6_cs0_sp", 32'(sp), 0);
    chk("t6_cs0_dout", 32'(DOut), 0);
    cs = 1; r = 0;
    // After a fresh reset, call+ret+inc arrive together; only the call may act.
    @(negedge clk); re = 0; #1; re = 1; @(negedge clk);
    call = 1; ret = 1; inc = 1; load = 16'h0200; tick();
    chk("t6_pri_pc", 32'(pc), 32'h0200);
    chk("t6_pri_sp", 32'(sp), 1);
    chk("t6_pri_unf", 32'(unf), 0);
    // ret outranks l and br.
    ret = 1; l = 1; br = 1; load = 16'h0777; offset = 16'h0010; tick();
    chk("t6_ret_over_l", 32'(pc), 32'h0001);
    chk("t6_ret_sp", 32'(sp), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
